// File: rtl/mul_div_unit_if.sv
// EX-stage bundle between the ID/EX operand path and the HI/LO multiply/divide unit.
// The EX stage drives the master side and the unit drives the slave side.
interface mul_div_unit_if #(
   parameter int DWIDTH = 32
);
   logic              en;
   logic              flush;
   logic [5:0]        functin;
   logic [DWIDTH-1:0] rsdata;
   logic [DWIDTH-1:0] rtdata;
   logic              busy;
   logic              hilostall;
   logic [DWIDTH-1:0] rdata;
   logic [DWIDTH-1:0] hi;
   logic [DWIDTH-1:0] lo;

   modport master (
      output en, flush, functin, rsdata, rtdata,
      input  busy, hilostall, rdata, hi, lo
   );

   modport slave (
      input  en, flush, functin, rsdata, rtdata,
      output busy, hilostall, rdata, hi, lo
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// It runs one shift-add or restoring-divide step per cycle, then applies the signs in a final FIX cycle.
module mul_div_unit #(
   parameter int DWIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   mul_div_unit_if.slave bus
);
   localparam int CW = $clog2(DWIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic [1:0]          state;
   logic [CW-1:0]       count;
   logic [2*DWIDTH-1:0] acc;
   logic [DWIDTH-1:0]   operand_b;
   logic                neg_q;
   logic                neg_r;
   logic                is_div;
   logic [DWIDTH-1:0]   hi_reg;
   logic [DWIDTH-1:0]   lo_reg;

   logic                accept;
   logic                is_signed;
   logic                hilo_op;
   logic [DWIDTH-1:0]   rs_mag;
   logic [DWIDTH-1:0]   rt_mag;
   logic [DWIDTH:0]     mul_sum;
   logic [DWIDTH:0]     div_shift;
   logic [DWIDTH+1:0]   div_diff;

   // The accumulator's upper half holds the partial product or the remainder, and its lower half holds
   // the multiplier or the dividend shifting into the quotient.
   always_comb begin
      accept    = (state == S_IDLE) && bus.en && !bus.flush;
      is_signed = (bus.functin == F_MULT) || (bus.functin == F_DIV);
      hilo_op   = (bus.functin == F_MFHI) || (bus.functin == F_MTHI) ||
                  (bus.functin == F_MFLO) || (bus.functin == F_MTLO) ||
                  (bus.functin == F_MULT) || (bus.functin == F_MULTU) ||
                  (bus.functin == F_DIV)  || (bus.functin == F_DIVU);
      rs_mag    = (is_signed && bus.rsdata[DWIDTH-1]) ? -bus.rsdata : bus.rsdata;
      rt_mag    = (is_signed && bus.rtdata[DWIDTH-1]) ? -bus.rtdata : bus.rtdata;
      mul_sum   = {1'b0, acc[2*DWIDTH-1:DWIDTH]} + {1'b0, (acc[0] ? operand_b : '0)};
      div_shift = {acc[2*DWIDTH-1:DWIDTH], acc[DWIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, operand_b};
   end

   assign bus.busy      = (state != S_IDLE);
   assign bus.hilostall = bus.en && !bus.flush && bus.busy && hilo_op;
   assign bus.rdata     = (bus.functin == F_MFHI) ? hi_reg : lo_reg;
   assign bus.hi        = hi_reg;
   assign bus.lo        = lo_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         count     <= '0;
         acc       <= '0;
         operand_b <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         is_div    <= 1'b0;
         hi_reg    <= '0;
         lo_reg    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (bus.functin)
                     F_MTHI: hi_reg <= bus.rsdata;
                     F_MTLO: lo_reg <= bus.rsdata;
                     F_MULT, F_MULTU: begin
                        acc       <= {{DWIDTH{1'b0}}, rs_mag};
                        operand_b <= rt_mag;
                        neg_q     <= is_signed && (bus.rsdata[DWIDTH-1] ^ bus.rtdata[DWIDTH-1]);
                        neg_r     <= 1'b0;
                        is_div    <= 1'b0;
                        count     <= '0;
                        state     <= S_MUL;
                     end
                     F_DIV, F_DIVU: begin
                        // A zero divisor makes every trial subtract succeed, so the quotient fills
                        // with ones and the raw dividend falls out as the remainder unsigned.
                        if (bus.rtdata == '0) begin
                           acc       <= {{DWIDTH{1'b0}}, bus.rsdata};
                           operand_b <= '0;
                           neg_q     <= 1'b0;
                           neg_r     <= 1'b0;
                        end else begin
                           acc       <= {{DWIDTH{1'b0}}, rs_mag};
                           operand_b <= rt_mag;
                           neg_q     <= is_signed && (bus.rsdata[DWIDTH-1] ^ bus.rtdata[DWIDTH-1]);
                           neg_r     <= is_signed && bus.rsdata[DWIDTH-1];
                        end
                        is_div <= 1'b1;
                        count  <= '0;
                        state  <= S_DIV;
                     end
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               acc   <= {mul_sum, acc[DWIDTH-1:1]};
               count <= count + 1'b1;
               if (count == CW'(DWIDTH - 1)) state <= S_FIX;
            end
            S_DIV: begin
               acc   <= {(div_diff[DWIDTH+1] ? div_shift[DWIDTH-1:0] : div_diff[DWIDTH-1:0]),
                         acc[DWIDTH-2:0], !div_diff[DWIDTH+1]};
               count <= count + 1'b1;
               if (count == CW'(DWIDTH - 1)) state <= S_FIX;
            end
            default: begin
               if (is_div) begin
                  lo_reg <= neg_q ? -acc[DWIDTH-1:0] : acc[DWIDTH-1:0];
                  hi_reg <= neg_r ? -acc[2*DWIDTH-1:DWIDTH] : acc[2*DWIDTH-1:DWIDTH];
               end else begin
                  {hi_reg, lo_reg} <= neg_q ? -acc : acc;
               end
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: expected HI/LO pairs are queued when an op is issued
// and popped once the unit drops busy.
module tb_mul_div_unit;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic clk;
   logic rst;
   int   testsRun;
   int   testsFailed;
   logic [63:0] expQ[$];

   mul_div_unit_if #(.DWIDTH(32)) bus ();

   mul_div_unit #(.DWIDTH(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one op at a negedge, queues its expected {hi,lo}, and counts the busy cycles until completion.
   task automatic applyStimulus(input logic [5:0] funct, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [63:0] expected, output int cycles);
      @(negedge clk);
      bus.en      = 1'b1;
      bus.flush   = 1'b0;
      bus.functin = funct;
      bus.rsdata  = rs;
      bus.rtdata  = rt;
      expQ.push_back(expected);
      @(negedge clk);
      bus.en      = 1'b0;
      bus.functin = 6'h00;
      cycles = 0;
      while (bus.busy === 1'b1 && cycles < 100) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      testsRun++;
      if (bus.hi !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_hi got %h want %h", bus.hi, 32'h0); end
      testsRun++;
      if (bus.lo !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_lo got %h want %h", bus.lo, 32'h0); end
      testsRun++;
      if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
      testsRun++;
      if (bus.rdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_rdata got %h want %h", bus.rdata, 32'h0); end
   endtask

   task automatic test_arith;
      logic [5:0]  fn  [6];
      logic [31:0] rsv [6];
      logic [31:0] rtv [6];
      logic [63:0] ev  [6];
      logic [63:0] exp;
      int cycles;
      fn[0] = F_MULT;  rsv[0] = 32'hFFFFFFFE; rtv[0] = 32'd3; ev[0] = {32'hFFFFFFFF, 32'hFFFFFFFA};
      fn[1] = F_MULTU; rsv[1] = 32'hFFFFFFFE; rtv[1] = 32'd3; ev[1] = {32'h00000002, 32'hFFFFFFFA};
      fn[2] = F_DIV;   rsv[2] = 32'hFFFFFFF9; rtv[2] = 32'd2; ev[2] = {32'hFFFFFFFF, 32'hFFFFFFFD};
      fn[3] = F_DIVU;  rsv[3] = 32'd7;        rtv[3] = 32'd2; ev[3] = {32'h00000001, 32'h00000003};
      fn[4] = F_DIVU;  rsv[4] = 32'h1234;     rtv[4] = 32'd0; ev[4] = {32'h00001234, 32'hFFFFFFFF};
      fn[5] = F_DIV;   rsv[5] = 32'h80000000; rtv[5] = 32'hFFFFFFFF; ev[5] = {32'h00000000, 32'h80000000};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(fn[i], rsv[i], rtv[i], ev[i], cycles);
         exp = expQ.pop_front();
         testsRun++;
         if (cycles != 33) begin
            testsFailed++;
            $display("[TB] FAIL op%0d_busy_cycles got %0d want 33", i, cycles);
         end
         testsRun++;
         if (bus.hi !== exp[63:32]) begin
            testsFailed++;
            $display("[TB] FAIL op%0d_hi got %h want %h", i, bus.hi, exp[63:32]);
         end
         testsRun++;
         if (bus.lo !== exp[31:0]) begin
            testsFailed++;
            $display("[TB] FAIL op%0d_lo got %h want %h", i, bus.lo, exp[31:0]);
         end
      end
   endtask

   task automatic test_hilo_stall;
      logic [63:0] exp;
      int stalls;
      int guard;
      @(negedge clk);
      bus.en      = 1'b1;
      bus.flush   = 1'b0;
      bus.functin = F_MULT;
      bus.rsdata  = 32'h00012345;
      bus.rtdata  = 32'h00000010;
      expQ.push_back(64'h0000000000123450);
      @(negedge clk);
      bus.functin = F_MFLO;
      stalls = 0;
      guard  = 0;
      while (bus.hilostall === 1'b1 && guard < 100) begin
         stalls++;
         guard++;
         @(negedge clk);
      end
      exp = expQ.pop_front();
      testsRun++;
      if (stalls != 33) begin testsFailed++; $display("[TB] FAIL mflo_stall_cycles got %0d want 33", stalls); end
      testsRun++;
      if (bus.rdata !== exp[31:0]) begin testsFailed++; $display("[TB] FAIL mflo_rdata got %h want %h", bus.rdata, exp[31:0]); end
      bus.functin = F_MFHI;
      #1;
      testsRun++;
      if (bus.rdata !== exp[63:32]) begin testsFailed++; $display("[TB] FAIL mfhi_rdata got %h want %h", bus.rdata, exp[63:32]); end
      bus.functin = F_MTHI;
      bus.rsdata  = 32'hCAFEBABE;
      @(negedge clk);
      bus.en = 1'b0;
      bus.functin = 6'h00;
      testsRun++;
      if (bus.hi !== 32'hCAFEBABE) begin testsFailed++; $display("[TB] FAIL mthi_hi got %h want %h", bus.hi, 32'hCAFEBABE); end
      testsRun++;
      if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mthi_busy got %b want 0", bus.busy); end
   endtask

   task automatic test_flush_reset;
      logic [63:0] exp;
      int cycles;
      @(negedge clk);
      bus.en      = 1'b1;
      bus.flush   = 1'b1;
      bus.functin = F_MULT;
      bus.rsdata  = 32'd9;
      bus.rtdata  = 32'd9;
      @(negedge clk);
      bus.en    = 1'b0;
      bus.flush = 1'b0;
      testsRun++;
      if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_busy got %b want 0", bus.busy); end
      bus.en      = 1'b1;
      bus.functin = F_DIV;
      bus.rsdata  = 32'd100;
      bus.rtdata  = 32'd7;
      @(negedge clk);
      bus.en      = 1'b0;
      bus.functin = 6'h00;
      repeat (9) @(negedge clk);
      testsRun++;
      if (bus.busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL div_midrun_busy got %b want 1", bus.busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      testsRun++;
      if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_busy got %b want 0", bus.busy); end
      testsRun++;
      if ({bus.hi, bus.lo} !== 64'h0) begin testsFailed++; $display("[TB] FAIL rst_mid_hilo got %h want %h", {bus.hi, bus.lo}, 64'h0); end
      applyStimulus(F_MULTU, 32'd5, 32'd6, 64'd30, cycles);
      exp = expQ.pop_front();
      testsRun++;
      if (cycles != 33) begin testsFailed++; $display("[TB] FAIL multu_after_rst_cycles got %0d want 33", cycles); end
      testsRun++;
      if ({bus.hi, bus.lo} !== exp) begin testsFailed++; $display("[TB] FAIL multu_after_rst got %h want %h", {bus.hi, bus.lo}, exp); end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst         = 1'b1;
      bus.en      = 1'b0;
      bus.flush   = 1'b0;
      bus.functin = 6'h00;
      bus.rsdata  = 32'h0;
      bus.rtdata  = 32'h0;
      test_reset();
      test_arith();
      test_hilo_stall();
      test_flush_reset();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
